// File: rtl/fsk_pkg.sv
// Shared definitions for the FSK transmit/receive path: FSM state encoding,
// counter width and the half-period tick calculation that the frequency
// comparator also uses.
package fsk_pkg;

    localparam int CNT_W = 32;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } fsk_state_t;

    // Clock ticks per half period of a tone (truncating 32-bit division).
    function automatic logic [CNT_W-1:0] half_period_ticks(
        input logic [CNT_W-1:0] clock_hz,
        input logic [CNT_W-1:0] freq_hz
    );
        logic [CNT_W-1:0] twice_freq;
        twice_freq = freq_hz << 1;
        return clock_hz / twice_freq;
    endfunction

endpackage

// File: rtl/fsk_tone_generator_if.sv
// Bit handshake between a data source and the FSK tone generator.
// The source offers one bit with data_valid; the generator takes it in any
// cycle where data_ready is also high.
interface fsk_tone_generator_if;

    logic data_valid;
    logic data_bit;
    logic data_ready;

    modport master (
        output data_valid,
        output data_bit,
        input  data_ready
    );

    modport slave (
        input  data_valid,
        input  data_bit,
        output data_ready
    );

endinterface

// File: rtl/fsk_half_period_divider.sv
// Half-period divider: counts clock ticks and flips the square-wave output
// every half_ticks cycles while run is high. A restart clears the counter
// but keeps the output level, so the waveform stays continuous when a new
// symbol begins. A wrap coinciding with a restart still toggles.
module fsk_half_period_divider
    import fsk_pkg::*;
(
    input  logic             clock,
    input  logic             clear_n,
    input  logic             run,
    input  logic             restart,
    input  logic [CNT_W-1:0] half_ticks,
    output logic             tx_out
);

    logic [CNT_W-1:0] half_cnt_reg;
    logic             tx_reg;
    logic             wrap;

    assign wrap   = run && (half_cnt_reg == (half_ticks - 32'd1));
    assign tx_out = tx_reg;

    // Half-period counter and output toggle.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            half_cnt_reg <= '0;
            tx_reg       <= 1'b0;
        end else begin
            if (wrap) begin
                tx_reg <= ~tx_reg;
            end
            if (restart || wrap) begin
                half_cnt_reg <= '0;
            end else if (run) begin
                half_cnt_reg <= half_cnt_reg + 32'd1;
            end
        end
    end

endmodule

// File: rtl/fsk_tone_generator.sv
// Two-tone FSK transmitter. Each accepted bit is sent for one symbol period
// as a square wave at FREQUENCY_1 (bit 0) or FREQUENCY_2 (bit 1). The output
// level carries over between symbols; a new bit may be accepted in the last
// symbol cycle so consecutive symbols have no gap.
//
// Build option: define FSK_TONE_GEN_IDLE_MARK_EN to keep a FREQUENCY_1 mark
// tone running while idle; otherwise the output holds its level in idle.
module fsk_tone_generator
    import fsk_pkg::*;
#(
    parameter int unsigned FREQUENCY_1 = 9000,
    parameter int unsigned FREQUENCY_2 = 11000,
    parameter int unsigned CLOCK       = 50000000,
    parameter int unsigned BIT_RATE    = 1000
) (
    input  logic                   clock,
    input  logic                   clear_n,
    input  logic                   enable,
    fsk_tone_generator_if.slave    tx_if,
    output logic                   tx_out,
    output logic                   busy,
    output logic [CNT_W-1:0]       symbols_sent
);

    localparam logic [CNT_W-1:0] HALF1    = half_period_ticks(CLOCK, FREQUENCY_1);
    localparam logic [CNT_W-1:0] HALF2    = half_period_ticks(CLOCK, FREQUENCY_2);
    localparam logic [CNT_W-1:0] SYM      = CLOCK / BIT_RATE;
    localparam logic [CNT_W-1:0] SYM_LAST = SYM - 32'd1;

`ifdef FSK_TONE_GEN_IDLE_MARK_EN
    localparam bit IDLE_MARK = 1'b1;
`else
    localparam bit IDLE_MARK = 1'b0;
`endif

    // Reject parameter sets that cannot produce two distinct tones.
    if (FREQUENCY_2 <= FREQUENCY_1) begin : g_bad_freq_order
        $error("fsk_tone_generator: FREQUENCY_2 must exceed FREQUENCY_1");
    end
    if (HALF2 < 32'd1) begin : g_bad_half2
        $error("fsk_tone_generator: FREQUENCY_2 too high for CLOCK");
    end
    if (SYM < 32'd2) begin : g_bad_sym
        $error("fsk_tone_generator: symbol period shorter than 2 clocks");
    end

    fsk_state_t       state_reg, state_next;
    logic [CNT_W-1:0] sym_cnt_reg, sym_cnt_next;
    logic             cur_bit_reg, cur_bit_next;
    logic [CNT_W-1:0] symbols_sent_reg, symbols_sent_next;

    logic             last_cycle;
    logic             ready;
    logic             accept;
    logic             sym_end;
    logic             div_run;
    logic             div_restart;
    logic [CNT_W-1:0] div_half;

    assign last_cycle = (state_reg == SEND) && (sym_cnt_reg == SYM_LAST);
    // clear_n is folded in so data_ready reads 0 throughout reset.
    assign ready      = clear_n && enable && ((state_reg == IDLE) || last_cycle);
    assign accept     = tx_if.data_valid && ready;
    assign sym_end    = enable && last_cycle;

    assign tx_if.data_ready = ready;
    assign busy             = (state_reg == SEND);
    assign symbols_sent     = symbols_sent_reg;

    // Divider runs in SEND (and in IDLE when the mark tone is built in);
    // idle always uses the bit-0 tone.
    assign div_run     = enable && ((state_reg == SEND) || (IDLE_MARK && (state_reg == IDLE)));
    assign div_restart = accept || sym_end;
    assign div_half    = ((state_reg == SEND) && cur_bit_reg) ? HALF2 : HALF1;

    // FSM, symbol counter and bit latch registers.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_reg        <= IDLE;
            sym_cnt_reg      <= '0;
            cur_bit_reg      <= 1'b0;
            symbols_sent_reg <= '0;
        end else begin
            state_reg        <= state_next;
            sym_cnt_reg      <= sym_cnt_next;
            cur_bit_reg      <= cur_bit_next;
            symbols_sent_reg <= symbols_sent_next;
        end
    end

    // Next-state logic: everything holds while enable is low.
    always_comb begin
        state_next        = state_reg;
        sym_cnt_next      = sym_cnt_reg;
        cur_bit_next      = cur_bit_reg;
        symbols_sent_next = symbols_sent_reg;
        if (enable) begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        state_next   = SEND;
                        sym_cnt_next = '0;
                        cur_bit_next = tx_if.data_bit;
                    end
                end
                SEND: begin
                    if (last_cycle) begin
                        symbols_sent_next = symbols_sent_reg + 32'd1;
                        sym_cnt_next      = '0;
                        if (accept) begin
                            cur_bit_next = tx_if.data_bit;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        sym_cnt_next = sym_cnt_reg + 32'd1;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    fsk_half_period_divider u_divider (
        .clock      (clock),
        .clear_n    (clear_n),
        .run        (div_run),
        .restart    (div_restart),
        .half_ticks (div_half),
        .tx_out     (tx_out)
    );

endmodule

// File: tb/tb_fsk_tone_generator.sv
// Directed testbench for fsk_tone_generator with CLOCK=100, FREQUENCY_1=5,
// FREQUENCY_2=10, BIT_RATE=2 (HALF1=10, HALF2=5, SYM=50). Edge numbers are
// counted from the accept edge (edge 0) of each scenario.
module tb_fsk_tone_generator;

    logic        clock;
    logic        clear_n;
    logic        enable;
    logic        tx_out;
    logic        busy;
    logic [31:0] symbols_sent;

    fsk_tone_generator_if tx_if ();

    fsk_tone_generator #(
        .FREQUENCY_1 (5),
        .FREQUENCY_2 (10),
        .CLOCK       (100),
        .BIT_RATE    (2)
    ) dut (
        .clock        (clock),
        .clear_n      (clear_n),
        .enable       (enable),
        .tx_if        (tx_if),
        .tx_out       (tx_out),
        .busy         (busy),
        .symbols_sent (symbols_sent)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int   errors = 0;
    int   checks = 0;
    int   edge_no;
    logic prev_tx;
    int   tog_q[$];
    int   exp_a[8];
    int   exp_sent;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    // Advance one clock edge, sample 1 time unit later and log any toggle.
    task automatic step();
        @(posedge clock);
        #1;
        edge_no++;
        if (tx_out !== prev_tx) tog_q.push_back(edge_no);
        prev_tx = tx_out;
    endtask

    task automatic step_to(input int n);
        while (edge_no < n) step();
    endtask

    // Offer a bit so that it is accepted at edge 0, then clear the toggle log.
    task automatic send_bit(input logic b);
        check_val("ready_before_accept", {31'd0, tx_if.data_ready}, 32'd1);
        tx_if.data_valid = 1'b1;
        tx_if.data_bit   = b;
        edge_no = -1;
        step();
        tx_if.data_valid = 1'b0;
        tog_q.delete();
        check_val("busy_at_accept", {31'd0, busy}, 32'd1);
    endtask

    task automatic check_toggles(input string tag, input int n);
        check_val({tag, "_count"}, tog_q.size(), n);
        for (int i = 0; i < n; i++) begin
            check_val($sformatf("%s_edge%0d", tag, i),
                      (i < tog_q.size()) ? tog_q[i] : -1, exp_a[i]);
        end
    endtask

    initial begin
        clear_n          = 1'b0;
        enable           = 1'b1;
        tx_if.data_valid = 1'b0;
        tx_if.data_bit   = 1'b0;
        exp_sent         = 0;
        edge_no          = 0;
        prev_tx          = 1'b0;

        // Scenario 1: reset values, then idle for 200 cycles.
        #2;
        check_val("rst_tx_out", {31'd0, tx_out}, 32'd0);
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        check_val("rst_ready", {31'd0, tx_if.data_ready}, 32'd0);
        check_val("rst_sent", symbols_sent, 32'd0);
        repeat (3) @(posedge clock);
        #1;
        clear_n = 1'b1;
        #1;
        check_val("rel_ready", {31'd0, tx_if.data_ready}, 32'd1);
        prev_tx = tx_out;
        tog_q.delete();
        edge_no = 0;
        step_to(200);
`ifdef FSK_TONE_GEN_IDLE_MARK_EN
        check_val("idle_toggles", tog_q.size(), 20);
`else
        check_val("idle_toggles", tog_q.size(), 0);
        check_val("idle_tx_level", {31'd0, tx_out}, 32'd0);
`endif
        check_val("idle_busy", {31'd0, busy}, 32'd0);

        // Scenario 2: single bit 0.
        send_bit(1'b0);
        step_to(49);
        check_val("s2_busy_e49", {31'd0, busy}, 32'd1);
        check_val("s2_ready_e49", {31'd0, tx_if.data_ready}, 32'd1);
        step_to(50);
        exp_sent = 1;
        check_val("s2_busy_e50", {31'd0, busy}, 32'd0);
        check_val("s2_sent", symbols_sent, exp_sent);
        exp_a = '{10, 20, 30, 40, 50, 0, 0, 0};
        check_toggles("s2_tog", 5);
`ifndef FSK_TONE_GEN_IDLE_MARK_EN
        check_val("s2_level", {31'd0, tx_out}, 32'd1);
`endif

        // Scenario 3: bits 1 then 0 back-to-back.
        send_bit(1'b1);
        step_to(48);
        check_val("s3_ready_e48", {31'd0, tx_if.data_ready}, 32'd0);
        step_to(49);
        check_val("s3_ready_e49", {31'd0, tx_if.data_ready}, 32'd1);
        tx_if.data_valid = 1'b1;
        tx_if.data_bit   = 1'b0;
        step();
        tx_if.data_valid = 1'b0;
        exp_sent = 2;
        check_val("s3_busy_e50", {31'd0, busy}, 32'd1);
        check_val("s3_sent_e50", symbols_sent, exp_sent);
        check_val("s3_bit1_toggles", tog_q.size(), 10);
        check_val("s3_bit1_first", (tog_q.size() > 0) ? tog_q[0] : -1, 5);
        check_val("s3_bit1_last", (tog_q.size() > 0) ? tog_q[tog_q.size()-1] : -1, 50);
`ifndef FSK_TONE_GEN_IDLE_MARK_EN
        check_val("s3_level_e50", {31'd0, tx_out}, 32'd1);
`endif
        tog_q.delete();
        step_to(100);
        exp_sent = 3;
        exp_a = '{60, 70, 80, 90, 100, 0, 0, 0};
        check_toggles("s3_bit0_tog", 5);
        check_val("s3_busy_e100", {31'd0, busy}, 32'd0);
        check_val("s3_sent_e100", symbols_sent, exp_sent);
`ifndef FSK_TONE_GEN_IDLE_MARK_EN
        check_val("s3_level_e100", {31'd0, tx_out}, 32'd0);
`endif

        // Scenario 4: enable low for 7 cycles in the middle of bit 0.
        send_bit(1'b0);
        step_to(12);
        enable = 1'b0;
        #1;
        check_val("s4_ready_disabled", {31'd0, tx_if.data_ready}, 32'd0);
        step_to(19);
        enable = 1'b1;
        step_to(56);
        check_val("s4_busy_e56", {31'd0, busy}, 32'd1);
        check_val("s4_sent_e56", symbols_sent, exp_sent);
        step_to(57);
        exp_sent = 4;
        check_val("s4_busy_e57", {31'd0, busy}, 32'd0);
        check_val("s4_sent_e57", symbols_sent, exp_sent);
        exp_a = '{10, 27, 37, 47, 57, 0, 0, 0};
        check_toggles("s4_tog", 5);

        // Scenario 5: asynchronous reset 23 cycles into a bit-1 symbol.
        send_bit(1'b1);
        step_to(23);
        #2;
        clear_n = 1'b0;
        #1;
        check_val("s5_tx_out", {31'd0, tx_out}, 32'd0);
        check_val("s5_busy", {31'd0, busy}, 32'd0);
        check_val("s5_ready", {31'd0, tx_if.data_ready}, 32'd0);
        check_val("s5_sent", symbols_sent, 32'd0);
        repeat (3) step();
        clear_n = 1'b1;
        #1;
        check_val("s5_busy_rel", {31'd0, busy}, 32'd0);
        check_val("s5_sent_rel", symbols_sent, 32'd0);

        // Scenario 6: idle tone behaviour, then a bit-1 accept.
        prev_tx = tx_out;
        tog_q.delete();
        edge_no = 0;
        step_to(30);
`ifdef FSK_TONE_GEN_IDLE_MARK_EN
        exp_a = '{10, 20, 30, 0, 0, 0, 0, 0};
        check_toggles("s6_idle_tog", 3);
`else
        check_val("s6_idle_toggles", tog_q.size(), 0);
`endif
        send_bit(1'b1);
        step_to(10);
        exp_a = '{5, 10, 0, 0, 0, 0, 0, 0};
        check_toggles("s6_bit1_tog", 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
